// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_stage
//  Description : Issue/capture stage wrapped around a 4-bit ALU. Operations
//                are buffered in a small FIFO; the head entry drives the ALU
//                operand/opcode ports. The ALU response is registered with
//                opcode-dependent flag masking and handed downstream over a
//                valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
    parameter int DATA_LEN = 4,
    parameter int DEPTH    = 4,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_LEN-1:0] in_a,
    input  logic [DATA_LEN-1:0] in_b,
    input  logic [3:0]          in_op,
    output logic [DATA_LEN-1:0] alu_a,
    output logic [DATA_LEN-1:0] alu_b,
    output logic [3:0]          alu_op,
    input  logic [DATA_LEN-1:0] alu_result,
    input  logic                alu_carry,
    input  logic                alu_zero,
    input  logic                alu_overflow,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_LEN-1:0] out_result,
    output logic [3:0]          out_flags,
    output logic [3:0]          out_op,
    output logic                busy,
    output logic [CNT_W-1:0]    op_count
);

    // Pointer width; DEPTH is a power of two so pointers wrap naturally.
    localparam int                 c_ptr_w    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ptr_w:0]   c_full_cnt = (c_ptr_w + 1)'(DEPTH);
    localparam logic [c_ptr_w:0]   c_cnt_one  = (c_ptr_w + 1)'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [3:0]         c_idle_op  = 4'b1111;
    localparam logic [3:0]         c_op_add   = 4'd0;
    localparam logic [3:0]         c_op_sub   = 4'd1;
    localparam logic [3:0]         c_op_max   = 4'd7;

    // FIFO storage and bookkeeping
    logic [DATA_LEN-1:0] r_mem_a  [DEPTH];
    logic [DATA_LEN-1:0] r_mem_b  [DEPTH];
    logic [3:0]          r_mem_op [DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_ptr_w:0]    r_count;

    // Output register
    logic                r_out_valid;
    logic [DATA_LEN-1:0] r_out_result;
    logic [3:0]          r_out_flags;
    logic [3:0]          r_out_op;
    logic [CNT_W-1:0]    r_op_count;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_issue;
    logic                w_out_hs;
    logic [3:0]          w_head_op;
    logic                w_carry;
    logic                w_overflow;
    logic                w_illegal;

    assign w_full  = (r_count == c_full_cnt);
    assign w_empty = (r_count == '0);

    // flush wins over every state-changing event in its cycle.
    assign w_push   = in_valid & ~w_full & ~flush;
    assign w_issue  = ~w_empty & (~r_out_valid | out_ready) & ~flush;
    assign w_out_hs = r_out_valid & out_ready & ~flush;

    // Head entry drives the ALU; an idle FIFO presents a recognisable no-op.
    assign w_head_op = w_empty ? c_idle_op : r_mem_op[r_rd_ptr];
    assign alu_a     = w_empty ? '0 : r_mem_a[r_rd_ptr];
    assign alu_b     = w_empty ? '0 : r_mem_b[r_rd_ptr];
    assign alu_op    = w_head_op;

    // Carry only means something for add, overflow for add/sub.
    assign w_carry    = (w_head_op == c_op_add) & alu_carry;
    assign w_overflow = ((w_head_op == c_op_add) | (w_head_op == c_op_sub)) & alu_overflow;
    assign w_illegal  = (w_head_op > c_op_max);

    // FIFO payload write; storage needs no reset since only occupied slots are read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr]  <= in_a;
            r_mem_b[r_wr_ptr]  <= in_b;
            r_mem_op[r_wr_ptr] <= in_op;
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_issue})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Capture the ALU response on issue; drop valid once consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_flags  <= '0;
            r_out_op     <= '0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_flags  <= '0;
            r_out_op     <= '0;
        end else if (w_issue) begin
            r_out_valid  <= 1'b1;
            r_out_result <= alu_result;
            r_out_flags  <= {w_carry, alu_zero, w_overflow, w_illegal};
            r_out_op     <= w_head_op;
        end else if (w_out_hs) begin
            r_out_valid  <= 1'b0;
        end
    end

    // Completed-handshake counter; survives flush, wraps freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count <= '0;
        end else if (w_out_hs) begin
            r_op_count <= r_op_count + CNT_W'(1);
        end
    end

    assign in_ready   = ~w_full;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_flags  = r_out_flags;
    assign out_op     = r_out_op;
    assign op_count   = r_op_count;
    assign busy       = ~w_empty | r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue_stage
//  Description : Scoreboard bench for alu_issue_stage with a behavioural
//                4-bit ALU attached to the ALU ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

    localparam int DATA_LEN = 4;
    localparam int DEPTH    = 4;
    localparam int CNT_W    = 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                flush = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [DATA_LEN-1:0] in_a = '0;
    logic [DATA_LEN-1:0] in_b = '0;
    logic [3:0]          in_op = '0;
    logic [DATA_LEN-1:0] alu_a;
    logic [DATA_LEN-1:0] alu_b;
    logic [3:0]          alu_op;
    logic [DATA_LEN-1:0] alu_result;
    logic                alu_carry;
    logic                alu_zero;
    logic                alu_overflow;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [DATA_LEN-1:0] out_result;
    logic [3:0]          out_flags;
    logic [3:0]          out_op;
    logic                busy;
    logic [CNT_W-1:0]    op_count;

    logic                force_carry = 1'b0;
    logic [4:0]          alu_sum;
    logic [4:0]          alu_dif;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] f;
        logic [3:0] op;
    } exp_t;

    exp_t exp_q[$];
    int   pop_cyc[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   idx;

    alu_issue_stage #(
        .DATA_LEN(DATA_LEN),
        .DEPTH   (DEPTH),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_op       (in_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .alu_carry   (alu_carry),
        .alu_zero    (alu_zero),
        .alu_overflow(alu_overflow),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_flags   (out_flags),
        .out_op      (out_op),
        .busy        (busy),
        .op_count    (op_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU; force_carry lets a test raise carry on any opcode.
    always_comb begin
        alu_sum      = {1'b0, alu_a} + {1'b0, alu_b};
        alu_dif      = {1'b0, alu_a} - {1'b0, alu_b};
        alu_result   = '0;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        case (alu_op)
            4'd0: begin
                alu_result   = alu_sum[3:0];
                alu_carry    = alu_sum[4];
                alu_overflow = (alu_a[3] == alu_b[3]) && (alu_sum[3] != alu_a[3]);
            end
            4'd1: begin
                alu_result   = alu_dif[3:0];
                alu_carry    = alu_dif[4];
                alu_overflow = (alu_a[3] != alu_b[3]) && (alu_dif[3] != alu_a[3]);
            end
            4'd2: alu_result = ~alu_a;
            4'd3: alu_result = alu_a & alu_b;
            4'd4: alu_result = alu_a | alu_b;
            4'd5: alu_result = alu_a ^ alu_b;
            4'd6: alu_result = (alu_a < alu_b) ? 4'd1 : 4'd0;
            4'd7: alu_result = (alu_a == alu_b) ? 4'd1 : 4'd0;
            default: alu_result = '0;
        endcase
        alu_carry = alu_carry | force_carry;
        alu_zero  = (alu_result == '0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every presented output against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && !flush && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got op %0h result %0h expected none", out_op, out_result);
            end else begin
                chk("out_result", {28'd0, out_result}, {28'd0, exp_q[0].r});
                chk("out_flags",  {28'd0, out_flags},  {28'd0, exp_q[0].f});
                chk("out_op",     {28'd0, out_op},     {28'd0, exp_q[0].op});
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    pop_cyc.push_back(cyc);
                end
            end
        end
    end

    // Offer one operation; its expectation is queued when it is accepted.
    task automatic send(input logic [3:0] ea, input logic [3:0] eb, input logic [3:0] eop,
                        input logic [3:0] er, input logic [3:0] ef);
        int   guard = 0;
        bit   done  = 0;
        exp_t e;
        in_valid = 1'b1;
        in_a     = ea;
        in_b     = eb;
        in_op    = eop;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                e.r = er;
                e.f = ef;
                e.op = eop;
                exp_q.push_back(e);
                done = 1;
            end else begin
                guard++;
                if (guard > 50) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout: got in_ready 0 expected 1");
                    done = 1;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int g = 0;
        while (busy && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("drain_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        // Reset state, observed while reset is asserted.
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_out_flags", {28'd0, out_flags}, 32'd0);
        chk("rst_op_count",  {24'd0, op_count},  32'd0);
        chk("idle_alu_op",   {28'd0, alu_op},    32'hF);
        chk("idle_alu_a",    {28'd0, alu_a},     32'd0);
        #22 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: add 7+9, two-cycle latency.
        out_ready = 1'b1;
        send(4'h7, 4'h9, 4'd0, 4'h0, 4'b1100);
        in_valid = 1'b0;
        chk("t1_alu_a", {28'd0, alu_a}, 32'h7);
        chk("t1_latency_c1", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("t1_latency_c2", {31'd0, out_valid}, 32'd1);
        wait_drain();
        chk("t1_op_count", {24'd0, op_count}, 32'd1);

        // 2: flag masking, illegal opcode, logic ops.
        force_carry = 1'b1;
        send(4'h3, 4'h5, 4'd3, 4'h1, 4'b0000);
        send(4'hC, 4'h2, 4'hA, 4'h0, 4'b0101);
        send(4'h0, 4'h0, 4'd2, 4'hF, 4'b0000);
        send(4'h2, 4'h9, 4'd6, 4'h1, 4'b0000);
        send(4'h5, 4'h5, 4'd7, 4'h1, 4'b0000);
        in_valid = 1'b0;
        wait_drain();
        force_carry = 1'b0;
        chk("t2_op_count", {24'd0, op_count}, 32'd6);

        // 3: backpressure fills the FIFO, then a burst drain.
        out_ready = 1'b0;
        send(4'h1, 4'h2, 4'd0, 4'h3, 4'b0000);
        send(4'h5, 4'h3, 4'd1, 4'h2, 4'b0000);
        send(4'h8, 4'h1, 4'd1, 4'h7, 4'b0010);
        send(4'h6, 4'h6, 4'd5, 4'h0, 4'b0100);
        send(4'h4, 4'h1, 4'd4, 4'h5, 4'b0000);
        in_valid = 1'b0;
        chk("t3_in_ready_full", {31'd0, in_ready}, 32'd0);
        chk("t3_busy", {31'd0, busy}, 32'd1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        idx = pop_cyc.size();
        out_ready = 1'b1;
        wait_drain();
        chk("t3_pops", pop_cyc.size() - idx, 32'd5);
        if (pop_cyc.size() >= idx + 5)
            chk("t3_burst_span", pop_cyc[idx + 4] - pop_cyc[idx], 32'd4);
        chk("t3_op_count", {24'd0, op_count}, 32'd11);

        // 4: full-rate stream of 16 adds, pointers wrap several times.
        idx = pop_cyc.size();
        for (int i = 0; i < 16; i++) begin
            send(4'(i), 4'h1, 4'd0, 4'(i + 1), {(i == 15), (i == 15), (i == 7), 1'b0});
        end
        in_valid = 1'b0;
        wait_drain();
        chk("t4_pops", pop_cyc.size() - idx, 32'd16);
        if (pop_cyc.size() >= idx + 16)
            chk("t4_stream_span", pop_cyc[idx + 15] - pop_cyc[idx], 32'd15);
        chk("t4_op_count", {24'd0, op_count}, 32'd27);

        // 5: flush with 3 queued and a result pending; handshake in flush cycle ignored.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(4'h1, 4'h1, 4'd0, 4'h2, 4'b0000);
        end
        in_valid = 1'b0;
        chk("t5_pre_out_valid", {31'd0, out_valid}, 32'd1);
        chk("t5_pre_in_ready",  {31'd0, in_ready},  32'd1);
        flush     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(negedge clk);
        exp_q.delete();
        @(posedge clk);
        #1;
        flush     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("t5_busy",      {31'd0, busy},      32'd0);
        chk("t5_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_in_ready",  {31'd0, in_ready},  32'd1);
        chk("t5_op_count",  {24'd0, op_count},  32'd27);
        chk("t5_alu_op",    {28'd0, alu_op},    32'hF);

        // 6: asynchronous reset mid-stream, then a clean op.
        out_ready = 1'b1;
        send(4'h2, 4'h2, 4'd0, 4'h4, 4'b0000);
        send(4'h2, 4'h2, 4'd0, 4'h4, 4'b0000);
        send(4'h2, 4'h2, 4'd0, 4'h4, 4'b0000);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_out_valid",  {31'd0, out_valid},  32'd0);
        chk("t6_out_result", {28'd0, out_result}, 32'd0);
        chk("t6_out_flags",  {28'd0, out_flags},  32'd0);
        chk("t6_busy",       {31'd0, busy},       32'd0);
        chk("t6_in_ready",   {31'd0, in_ready},   32'd1);
        chk("t6_op_count",   {24'd0, op_count},   32'd0);
        exp_q.delete();
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(4'h1, 4'h1, 4'd0, 4'h2, 4'b0000);
        in_valid = 1'b0;
        wait_drain();
        chk("t6_post_op_count", {24'd0, op_count}, 32'd1);
        chk("final_queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
